// File: rtl/rvee_lsu_mo.sv
// rvee_lsu_mo: in-order load/store unit with an AXI4-Lite master port.
// Memory requests are tracked in a small FIFO so responses can be matched
// back to their destination register; misaligned accesses trap instead of
// reaching the bus, and non-memory ops simply forward their ALU result.
module rvee_lsu_mo #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_load,
  input  logic                req_store,
  input  logic [1:0]          req_size,
  input  logic                req_sext,
  input  logic [AWIDTH-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  input  logic                req_rd_we,
  input  logic [XLEN-1:0]     req_result,
  input  logic [XLEN-1:0]     req_pc,
  output logic [AWIDTH-1:0]   axi_araddr,
  output logic [2:0]          axi_arprot,
  output logic                axi_arvalid,
  input  logic                axi_arready,
  input  logic [XLEN-1:0]     axi_rdata,
  input  logic [1:0]          axi_rresp,
  input  logic                axi_rvalid,
  output logic                axi_rready,
  output logic [AWIDTH-1:0]   axi_awaddr,
  output logic [2:0]          axi_awprot,
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [XLEN-1:0]     axi_wdata,
  output logic [XLEN/8-1:0]   axi_wstrb,
  output logic                axi_wvalid,
  input  logic                axi_wready,
  input  logic [1:0]          axi_bresp,
  input  logic                axi_bvalid,
  output logic                axi_bready,
  output logic                wb_we,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                exc_valid,
  output logic [3:0]          exc_cause,
  output logic [XLEN-1:0]     exc_pc,
  output logic [AWIDTH-1:0]   exc_addr,
  output logic                busy
);

  localparam int NBYTES = XLEN / 8;
  localparam int OFFW   = $clog2(NBYTES);
  localparam int PTRW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic            load;
    logic [4:0]      rd;
    logic [1:0]      size;
    logic            sext;
    logic [OFFW-1:0] off;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  entry_t            head;
  entry_t            push_entry;
  logic [PTRW-1:0]   wr_ptr;
  logic [PTRW-1:0]   rd_ptr;
  logic [CNTW-1:0]   count;
  logic              inflight_load;
  logic              resp_ready;

  logic              is_mem;
  logic              misaligned;
  logic              kind_ok;
  logic              chan_free;
  logic              mem_ok;
  logic              nonmem_ok;
  logic              push;
  logic              pop;
  logic [OFFW-1:0]   req_off;
  logic [7:0]        mask8;
  logic [NBYTES-1:0] strb_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_data;
  logic              unused;

  assign axi_arprot = 3'b000;
  assign axi_awprot = 3'b000;
  assign axi_rready = resp_ready;
  assign axi_bready = resp_ready;
  assign busy       = (count != '0);
  assign unused     = ^{axi_rresp, axi_bresp, mask8};

  // Request acceptance: alignment, FIFO room, no load/store mixing, free address channels
  always_comb begin
    req_off    = req_addr[OFFW-1:0];
    is_mem     = req_load | req_store;
    misaligned = is_mem && ((int'(req_off) + (1 << req_size)) > NBYTES);
    kind_ok    = (count == '0) || (req_load == inflight_load);
    chan_free  = !(axi_arvalid && !axi_arready) &&
                 !(axi_awvalid && !axi_awready) &&
                 !(axi_wvalid && !axi_wready);
    mem_ok     = is_mem && !misaligned && (count < CNTW'(DEPTH)) && kind_ok && chan_free;
    nonmem_ok  = !is_mem && (count == '0);
    req_ready  = rst_n && req_valid && (misaligned || mem_ok || nonmem_ok);
    push       = rst_n && req_valid && mem_ok;
    push_entry = '{load: req_load, rd: req_rd, size: req_size, sext: req_sext, off: req_off};
    head       = fifo_q[rd_ptr];
    pop        = (count != '0) &&
                 ((axi_rvalid && resp_ready && head.load) ||
                  (axi_bvalid && resp_ready && !head.load));
  end

  // Store lane placement: size mask and data both move up by the byte offset
  always_comb begin
    case (req_size)
      2'd0:    mask8 = 8'h01;
      2'd1:    mask8 = 8'h03;
      2'd2:    mask8 = 8'h0F;
      default: mask8 = 8'hFF;
    endcase
    strb_c  = mask8[NBYTES-1:0] << req_off;
    wdata_c = req_wdata << {req_off, 3'b000};
  end

  // Load result alignment and zero/sign extension for the entry at the FIFO head
  always_comb begin
    shifted = axi_rdata >> {head.off, 3'b000};
    case (head.size)
      2'd0:    load_data = head.sext ? XLEN'($signed(shifted[7:0]))  : XLEN'(shifted[7:0]);
      2'd1:    load_data = head.sext ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
      2'd2:    load_data = head.sext ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
      default: load_data = shifted;
    endcase
  end

  // Response ready is low only while reset is applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_ready <= 1'b0;
    else        resp_ready <= 1'b1;
  end

  // FIFO pointers, occupancy and the kind of whatever is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      inflight_load <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr        <= (wr_ptr == PTRW'(DEPTH - 1)) ? '0 : wr_ptr + PTRW'(1);
        inflight_load <= req_load;
      end
      if (pop) rd_ptr <= (rd_ptr == PTRW'(DEPTH - 1)) ? '0 : rd_ptr + PTRW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage carries no reset; pointers alone decide validity
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= push_entry;
  end

  // AXI address/data channels: raise on accept, drop on each channel's own handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi_arvalid <= 1'b0;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_araddr  <= '0;
      axi_awaddr  <= '0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
    end else begin
      if (axi_arvalid && axi_arready) axi_arvalid <= 1'b0;
      if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
      if (axi_wvalid && axi_wready)   axi_wvalid  <= 1'b0;
      if (push) begin
        if (req_load) begin
          axi_arvalid <= 1'b1;
          axi_araddr  <= req_addr;
        end else begin
          axi_awvalid <= 1'b1;
          axi_awaddr  <= req_addr;
          axi_wvalid  <= 1'b1;
          axi_wdata   <= wdata_c;
          axi_wstrb   <= strb_c;
        end
      end
    end
  end

  // Writeback from load responses or forwarded ALU results, plus the misalign trap pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      exc_valid <= 1'b0;
      exc_cause <= '0;
      exc_pc    <= '0;
      exc_addr  <= '0;
    end else begin
      if (pop && head.load) begin
        wb_we   <= 1'b1;
        wb_rd   <= head.rd;
        wb_data <= load_data;
      end else if (req_valid && nonmem_ok) begin
        wb_we   <= req_rd_we;
        wb_rd   <= req_rd;
        wb_data <= req_result;
      end else begin
        wb_we   <= 1'b0;
      end
      exc_valid <= req_valid && misaligned;
      if (req_valid && misaligned) begin
        exc_cause <= req_load ? 4'd4 : 4'd6;
        exc_pc    <= req_pc;
        exc_addr  <= req_addr;
      end
    end
  end

endmodule

// File: tb/tb_rvee_lsu_mo.sv
// tb_rvee_lsu_mo: directed self-checking bench for rvee_lsu_mo (XLEN=32, DEPTH=4).
module tb_rvee_lsu_mo;

  localparam int XLEN   = 32;
  localparam int AWIDTH = 32;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_sext;
  logic [AWIDTH-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;
  logic              req_rd_we;
  logic [XLEN-1:0]   req_result;
  logic [XLEN-1:0]   req_pc;
  logic [AWIDTH-1:0] axi_araddr;
  logic [2:0]        axi_arprot;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [XLEN-1:0]   axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rvalid;
  logic              axi_rready;
  logic [AWIDTH-1:0] axi_awaddr;
  logic [2:0]        axi_awprot;
  logic              axi_awvalid;
  logic              axi_awready;
  logic [XLEN-1:0]   axi_wdata;
  logic [XLEN/8-1:0] axi_wstrb;
  logic              axi_wvalid;
  logic              axi_wready;
  logic [1:0]        axi_bresp;
  logic              axi_bvalid;
  logic              axi_bready;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              exc_valid;
  logic [3:0]        exc_cause;
  logic [XLEN-1:0]   exc_pc;
  logic [AWIDTH-1:0] exc_addr;
  logic              busy;

  int n_cmp  = 0;
  int n_fail = 0;

  rvee_lsu_mo #(.XLEN(XLEN), .AWIDTH(AWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
    .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .req_rd_we(req_rd_we), .req_result(req_result), .req_pc(req_pc),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_addr(exc_addr),
    .busy(busy)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_req();
    req_valid = 0; req_load = 0; req_store = 0; req_size = 0; req_sext = 0;
    req_addr = 0; req_wdata = 0; req_rd = 0; req_rd_we = 0; req_result = 0; req_pc = 0;
  endtask

  task automatic drive_mem(input logic ld, input logic [31:0] addr, input logic [1:0] size,
                           input logic sext, input logic [4:0] rd, input logic [31:0] wd,
                           input logic [31:0] pc);
    req_valid = 1; req_load = ld; req_store = !ld; req_size = size; req_sext = sext;
    req_addr = addr; req_rd = rd; req_rd_we = ld; req_wdata = wd; req_pc = pc; req_result = 0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic we, input logic [31:0] res);
    req_valid = 1; req_load = 0; req_store = 0; req_size = 0; req_sext = 0;
    req_addr = 0; req_rd = rd; req_rd_we = we; req_wdata = 0; req_pc = 0; req_result = res;
  endtask

  task automatic test_reset();
    rst_n = 1; clear_req();
    axi_arready = 1; axi_awready = 1; axi_wready = 1;
    axi_rvalid = 0; axi_rdata = 0; axi_rresp = 0; axi_bvalid = 0; axi_bresp = 0;
    #2 rst_n = 0;
    drive_mem(1, 32'h100, 2, 0, 5'd1, 0, 0);
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++; if (axi_arvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_arvalid: got %b want 0", axi_arvalid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({axi_rready, axi_bready} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_resp_ready: got %b want 00", {axi_rready, axi_bready}); end
    n_cmp++; if ({wb_we, exc_valid, axi_awvalid, axi_wvalid} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_misc: got %b want 0000", {wb_we, exc_valid, axi_awvalid, axi_wvalid}); end
    clear_req();
    rst_n = 1;
    @(negedge clk);
    n_cmp++; if ({axi_rready, axi_bready} !== 2'b11) begin n_fail++; $display("[TB] FAIL post_reset_resp_ready: got %b want 11", {axi_rready, axi_bready}); end
  endtask

  task automatic test_load_word();
    @(negedge clk);
    drive_mem(1, 32'h100, 2, 0, 5'd5, 0, 0); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_ready: got %b want 1", req_ready); end
    @(negedge clk); clear_req();
    n_cmp++; if (axi_arvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_arvalid: got %b want 1", axi_arvalid); end
    n_cmp++; if (axi_araddr !== 32'h100) begin n_fail++; $display("[TB] FAIL lw_araddr: got %h want 00000100", axi_araddr); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_busy: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if ({axi_arvalid, wb_we} !== 2'b00) begin n_fail++; $display("[TB] FAIL lw_ar_done: got %b want 00", {axi_arvalid, wb_we}); end
    axi_rvalid = 1; axi_rdata = 32'hDEADBEEF;
    @(negedge clk); axi_rvalid = 0;
    n_cmp++; if (wb_we !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_wb_we: got %b want 1", wb_we); end
    n_cmp++; if (wb_rd !== 5'd5) begin n_fail++; $display("[TB] FAIL lw_wb_rd: got %0d want 5", wb_rd); end
    n_cmp++; if (wb_data !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL lw_wb_data: got %h want deadbeef", wb_data); end
    @(negedge clk);
    n_cmp++; if ({wb_we, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL lw_idle: got %b want 00", {wb_we, busy}); end
  endtask

  task automatic test_load_ext();
    logic [31:0] addr_t [3] = '{32'h102, 32'h102, 32'h101};
    logic [1:0]  size_t [3] = '{2'd1, 2'd1, 2'd0};
    logic        sext_t [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] rdat_t [3] = '{32'h8001_0000, 32'h8001_0000, 32'h0000_F000};
    logic [31:0] exp_t  [3] = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FFF0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_mem(1, addr_t[i], size_t[i], sext_t[i], 5'(7 + i), 0, 0);
      @(negedge clk); clear_req();
      @(negedge clk); axi_rvalid = 1; axi_rdata = rdat_t[i];
      @(negedge clk); axi_rvalid = 0;
      n_cmp++; if ({wb_we, wb_rd} !== {1'b1, 5'(7 + i)}) begin n_fail++; $display("[TB] FAIL ext%0d_wb: got %b/%0d want 1/%0d", i, wb_we, wb_rd, 7 + i); end
      n_cmp++; if (wb_data !== exp_t[i]) begin n_fail++; $display("[TB] FAIL ext%0d_data: got %h want %h", i, wb_data, exp_t[i]); end
    end
  endtask

  task automatic test_store_byte();
    @(negedge clk);
    drive_mem(0, 32'h103, 0, 0, 5'd0, 32'h0000_00AB, 0); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL sb_ready: got %b want 1", req_ready); end
    @(negedge clk); clear_req();
    n_cmp++; if ({axi_awvalid, axi_wvalid, axi_arvalid} !== 3'b110) begin n_fail++; $display("[TB] FAIL sb_valids: got %b want 110", {axi_awvalid, axi_wvalid, axi_arvalid}); end
    n_cmp++; if (axi_wstrb !== 4'b1000) begin n_fail++; $display("[TB] FAIL sb_wstrb: got %b want 1000", axi_wstrb); end
    n_cmp++; if (axi_wdata[31:24] !== 8'hAB) begin n_fail++; $display("[TB] FAIL sb_wdata: got %h want ab", axi_wdata[31:24]); end
    n_cmp++; if (axi_awaddr !== 32'h103) begin n_fail++; $display("[TB] FAIL sb_awaddr: got %h want 00000103", axi_awaddr); end
    @(negedge clk);
    n_cmp++; if ({axi_awvalid, axi_wvalid} !== 2'b00) begin n_fail++; $display("[TB] FAIL sb_hs: got %b want 00", {axi_awvalid, axi_wvalid}); end
    axi_bvalid = 1;
    @(negedge clk); axi_bvalid = 0;
    n_cmp++; if ({wb_we, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL sb_no_wb: got %b want 00", {wb_we, busy}); end
  endtask

  task automatic test_store_backpressure();
    @(negedge clk);
    axi_wready = 0;
    drive_mem(0, 32'h104, 2, 0, 5'd0, 32'h1122_3344, 0);
    @(negedge clk); clear_req();
    n_cmp++; if (axi_wstrb !== 4'b1111) begin n_fail++; $display("[TB] FAIL sw_wstrb: got %b want 1111", axi_wstrb); end
    @(negedge clk);
    n_cmp++; if ({axi_awvalid, axi_wvalid} !== 2'b01) begin n_fail++; $display("[TB] FAIL sw_w_held: got %b want 01", {axi_awvalid, axi_wvalid}); end
    drive_mem(0, 32'h108, 2, 0, 5'd0, 32'h5555_5555, 0); #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_blocked: got %b want 0", req_ready); end
    clear_req(); axi_wready = 1;
    @(negedge clk);
    n_cmp++; if (axi_wvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_w_done: got %b want 0", axi_wvalid); end
    axi_bvalid = 1;
    @(negedge clk); axi_bvalid = 0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_busy: got %b want 0", busy); end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    drive_mem(1, 32'h101, 2, 0, 5'd3, 0, 32'h2000); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mis_ld_ready: got %b want 1", req_ready); end
    @(negedge clk); clear_req();
    n_cmp++; if ({exc_valid, exc_cause} !== {1'b1, 4'd4}) begin n_fail++; $display("[TB] FAIL mis_ld_exc: got %b/%0d want 1/4", exc_valid, exc_cause); end
    n_cmp++; if ({exc_addr, exc_pc} !== {32'h101, 32'h2000}) begin n_fail++; $display("[TB] FAIL mis_ld_info: got %h/%h want 00000101/00002000", exc_addr, exc_pc); end
    n_cmp++; if ({axi_arvalid, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL mis_ld_no_axi: got %b want 00", {axi_arvalid, busy}); end
    drive_mem(0, 32'h103, 1, 0, 5'd0, 32'hBEEF, 32'h2004);
    @(negedge clk); clear_req();
    n_cmp++; if ({exc_valid, exc_cause} !== {1'b1, 4'd6}) begin n_fail++; $display("[TB] FAIL mis_st_exc: got %b/%0d want 1/6", exc_valid, exc_cause); end
    n_cmp++; if ({axi_awvalid, axi_wvalid, busy} !== 3'b000) begin n_fail++; $display("[TB] FAIL mis_st_no_axi: got %b want 000", {axi_awvalid, axi_wvalid, busy}); end
    @(negedge clk);
    n_cmp++; if (exc_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_pulse: got %b want 0", exc_valid); end
  endtask

  task automatic test_nonmem();
    @(negedge clk);
    drive_alu(5'd10, 1, 32'h1234_5678); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL alu_ready: got %b want 1", req_ready); end
    @(negedge clk);
    n_cmp++; if ({wb_we, wb_rd, wb_data} !== {1'b1, 5'd10, 32'h1234_5678}) begin n_fail++; $display("[TB] FAIL alu_wb: got %b/%0d/%h want 1/10/12345678", wb_we, wb_rd, wb_data); end
    drive_mem(1, 32'h400, 2, 0, 5'd11, 0, 0);
    @(negedge clk);
    drive_alu(5'd12, 1, 32'h0000_CAFE); #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_blocked: got %b want 0", req_ready); end
    axi_rvalid = 1; axi_rdata = 32'h0000_0099;
    @(negedge clk); axi_rvalid = 0; #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL alu_unblocked: got %b want 1", req_ready); end
    n_cmp++; if ({wb_rd, wb_data} !== {5'd11, 32'h99}) begin n_fail++; $display("[TB] FAIL alu_load_wb: got %0d/%h want 11/00000099", wb_rd, wb_data); end
    @(negedge clk); clear_req();
    n_cmp++; if ({wb_we, wb_rd, wb_data} !== {1'b1, 5'd12, 32'hCAFE}) begin n_fail++; $display("[TB] FAIL alu_wb2: got %b/%0d/%h want 1/12/0000cafe", wb_we, wb_rd, wb_data); end
  endtask

  task automatic test_depth();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_mem(1, 32'h200 + 32'(4 * i), 2, 0, 5'(i + 1), 0, 0); #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL depth_acc%0d: got %b want 1", i, req_ready); end
    end
    @(negedge clk);
    drive_mem(1, 32'h210, 2, 0, 5'd5, 0, 0); #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL depth_full: got %b want 0", req_ready); end
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL depth_full2: got %b want 0", req_ready); end
    axi_rvalid = 1; axi_rdata = 32'h11;
    @(negedge clk); axi_rvalid = 0; #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL depth_free: got %b want 1", req_ready); end
    n_cmp++; if ({wb_we, wb_rd, wb_data} !== {1'b1, 5'd1, 32'h11}) begin n_fail++; $display("[TB] FAIL depth_wb1: got %b/%0d/%h want 1/1/00000011", wb_we, wb_rd, wb_data); end
    @(negedge clk); clear_req();
    axi_rvalid = 1;
    for (int k = 0; k < 4; k++) begin
      axi_rdata = 32'h20 + 32'(k);
      @(negedge clk);
      n_cmp++; if ({wb_we, wb_rd, wb_data} !== {1'b1, 5'(k + 2), 32'h20 + 32'(k)}) begin n_fail++; $display("[TB] FAIL depth_drain%0d: got %b/%0d/%h want 1/%0d/%h", k, wb_we, wb_rd, wb_data, k + 2, 32'h20 + k); end
    end
    axi_rvalid = 0;
    @(negedge clk);
    n_cmp++; if ({busy, wb_we} !== 2'b00) begin n_fail++; $display("[TB] FAIL depth_idle: got %b want 00", {busy, wb_we}); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_mem(1, 32'h600, 2, 0, 5'd1, 0, 0);
    @(negedge clk);
    drive_mem(1, 32'h604, 2, 0, 5'd2, 0, 0); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready: got %b want 1", req_ready); end
    axi_rvalid = 1; axi_rdata = 32'h55;
    @(negedge clk); clear_req(); axi_rvalid = 0;
    n_cmp++; if ({busy, wb_rd, wb_data} !== {1'b1, 5'd1, 32'h55}) begin n_fail++; $display("[TB] FAIL b2b_pushpop: got %b/%0d/%h want 1/1/00000055", busy, wb_rd, wb_data); end
    @(negedge clk); axi_rvalid = 1; axi_rdata = 32'h66;
    @(negedge clk); axi_rvalid = 0;
    n_cmp++; if ({busy, wb_we, wb_rd, wb_data} !== {1'b0, 1'b1, 5'd2, 32'h66}) begin n_fail++; $display("[TB] FAIL b2b_last: got %b/%b/%0d/%h want 0/1/2/00000066", busy, wb_we, wb_rd, wb_data); end
  endtask

  task automatic test_mixing();
    @(negedge clk);
    drive_mem(1, 32'h300, 2, 0, 5'd8, 0, 0);
    @(negedge clk);
    drive_mem(1, 32'h304, 2, 0, 5'd9, 0, 0);
    @(negedge clk);
    drive_mem(0, 32'h308, 2, 0, 5'd0, 32'hA5A5_A5A5, 0); #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mix_hold0: got %b want 0", req_ready); end
    @(negedge clk);
    axi_rvalid = 1; axi_rdata = 32'h1; #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mix_hold1: got %b want 0", req_ready); end
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mix_hold2: got %b want 0", req_ready); end
    @(negedge clk); axi_rvalid = 0; #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mix_release: got %b want 1", req_ready); end
    @(negedge clk); clear_req();
    n_cmp++; if ({axi_awvalid, axi_wvalid, axi_wdata} !== {2'b11, 32'hA5A5_A5A5}) begin n_fail++; $display("[TB] FAIL mix_store: got %b/%h want 11/a5a5a5a5", {axi_awvalid, axi_wvalid}, axi_wdata); end
    @(negedge clk); axi_bvalid = 1;
    @(negedge clk); axi_bvalid = 0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL mix_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    drive_mem(1, 32'h500, 2, 0, 5'd13, 0, 0);
    @(negedge clk); clear_req();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_busy: got %b want 1", busy); end
    rst_n = 0; #1;
    n_cmp++; if ({busy, axi_arvalid, axi_rready} !== 3'b000) begin n_fail++; $display("[TB] FAIL rmid_clear: got %b want 000", {busy, axi_arvalid, axi_rready}); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    n_cmp++; if (axi_rready !== 1'b1) begin n_fail++; $display("[TB] FAIL rmid_rready: got %b want 1", axi_rready); end
    axi_rvalid = 1; axi_rdata = 32'h77;
    @(negedge clk); axi_rvalid = 0;
    n_cmp++; if ({wb_we, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL rmid_drop: got %b want 00", {wb_we, busy}); end
  endtask

  // Scenario sequence
  initial begin
    $display("[TB] starting rvee_lsu_mo directed tests");
    test_reset();
    test_load_word();
    test_load_ext();
    test_store_byte();
    test_store_backpressure();
    test_misaligned();
    test_nonmem();
    test_depth();
    test_back_to_back();
    test_mixing();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
